// File: rtl/cellrv32_package.sv
// ---------------------------------------------------------------------------
// cellrv32_package
// Shared FPU definitions for the co-processor converters.
//   - fp_exc_*_c    : bit indices into the 5-bit {NV,DZ,OF,UF,NX} flag vector
//   - fp_rmode_t    : RISC-V rounding modes as encoded in the frm/rm field
//   - fp_round_en   : round-increment decision shared by i2f and f2i
//   - fp_i2f_exp_init_c : biased exponent of an integer whose MSB is bit 31
// ---------------------------------------------------------------------------
package cellrv32_package;

    // exception flag indices
    localparam int fp_exc_nv_c = 4;
    localparam int fp_exc_dz_c = 3;
    localparam int fp_exc_of_c = 2;
    localparam int fp_exc_uf_c = 1;
    localparam int fp_exc_nx_c = 0;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } fp_rmode_t;

    // 127 + 31: exponent before normalization shifts are applied
    localparam logic [7:0] fp_i2f_exp_init_c = 8'd158;

    // Decide whether the truncated magnitude gets +1 ulp.
    // Reserved encodings (101..111) behave like RTZ.
    function automatic logic fp_round_en(input logic [2:0] rmode,
                                         input logic       sign,
                                         input logic       lsb,
                                         input logic       g,
                                         input logic       r,
                                         input logic       s);
        logic en;
        en = 1'b0;
        case (rmode)
            RNE:     en = g & (r | s | lsb);
            RTZ:     en = 1'b0;
            RDN:     en = sign & (g | r | s);
            RUP:     en = ~sign & (g | r | s);
            RMM:     en = g;
            default: en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_fpu_i2f.sv
// ---------------------------------------------------------------------------
// cellrv32_cpu_cp_fpu_i2f
// Multi-cycle 32-bit integer to binary32 converter (FCVT.S.W / FCVT.S.WU).
// Normalizes one bit per cycle, then rounds according to the captured
// rounding mode and reports inexact.
// Ports:
//   clk_i, rstn_i   clock, async active-low reset
//   start_i         start a conversion (only honoured when idle)
//   rmode_i         rounding mode, sampled with start_i
//   funct_i         0 = signed, 1 = unsigned source, sampled with start_i
//   data_i          integer operand, sampled with start_i
//   result_o        binary32 result, held until next completion
//   flags_o         {NV,DZ,OF,UF,NX}, updated together with result_o
//   done_o          one-cycle completion pulse
// Latency (sampling edge counted as 1): nonzero = lz+5 edges, zero = 3 edges.
// ---------------------------------------------------------------------------
module cellrv32_cpu_cp_fpu_i2f
    import cellrv32_package::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      rmode_i,
    input  logic            funct_i,
    input  logic [XLEN-1:0] data_i,
    output logic [31:0]     result_o,
    output logic [4:0]      flags_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_NORMALIZE,
        S_ROUND,
        S_FINALIZE
    } state_t;

    state_t      state_q, state_d;

    logic        unsigned_q;
    logic [2:0]  rmode_q;
    logic        sign_q;
    logic [31:0] mag_q;
    logic [7:0]  exp_q;
    logic [22:0] mant_q;
    logic        zero_q;
    logic        inexact_q;

    // sign is decided from the raw captured operand, before negation
    logic        sign_pre;
    assign sign_pre = ~unsigned_q & mag_q[31];

    // rounding: guard/round/sticky sit below the 23 kept mantissa bits
    logic        rnd_g, rnd_r, rnd_s, rnd_en;
    logic [30:0] rnd_sum;

    always_comb begin
        rnd_g   = mag_q[7];
        rnd_r   = mag_q[6];
        rnd_s   = |mag_q[5:0];
        rnd_en  = fp_round_en(rmode_q, sign_q, mag_q[8], rnd_g, rnd_r, rnd_s);
        // mantissa carry ripples straight into the exponent field
        rnd_sum = {exp_q, mag_q[30:8]} + {30'd0, rnd_en};
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_i) state_d = S_PREPARE;
            S_PREPARE: begin
                if (mag_q == 32'd0) state_d = S_FINALIZE;
                else                state_d = S_NORMALIZE;
            end
            S_NORMALIZE: if (mag_q[31]) state_d = S_ROUND;
            S_ROUND:     state_d = S_FINALIZE;
            S_FINALIZE:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // datapath
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            unsigned_q <= 1'b0;
            rmode_q    <= 3'd0;
            sign_q     <= 1'b0;
            mag_q      <= 32'd0;
            exp_q      <= 8'd0;
            mant_q     <= 23'd0;
            zero_q     <= 1'b0;
            inexact_q  <= 1'b0;
            result_o   <= 32'd0;
            flags_o    <= 5'd0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mag_q      <= data_i;
                        unsigned_q <= funct_i;
                        rmode_q    <= rmode_i;
                    end
                end
                S_PREPARE: begin
                    sign_q    <= sign_pre;
                    // 0x80000000 negates to itself, which is the right magnitude
                    mag_q     <= sign_pre ? (32'd0 - mag_q) : mag_q;
                    exp_q     <= fp_i2f_exp_init_c;
                    zero_q    <= (mag_q == 32'd0);
                    inexact_q <= 1'b0;
                end
                S_NORMALIZE: begin
                    if (!mag_q[31]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - 8'd1;
                    end
                end
                S_ROUND: begin
                    exp_q     <= rnd_sum[30:23];
                    mant_q    <= rnd_sum[22:0];
                    inexact_q <= rnd_g | rnd_r | rnd_s;
                end
                S_FINALIZE: begin
                    // zero path never yields -0
                    result_o               <= zero_q ? 32'd0 : {sign_q, exp_q, mant_q};
                    flags_o                <= 5'd0;
                    flags_o[fp_exc_nx_c]   <= zero_q ? 1'b0 : inexact_q;
                    done_o                 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
